pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles each PLL reset is held asserted before release (1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000000: maximum cycles spent waiting for a lock (1..2^24-1).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of clk.
REQ-004 SHALL have port clk, input, 1: system clock.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port cmd_word, input, 32: HPS PIO command; bit0 run request, bit1 AES hold, bit2 clear sticky flags; bits 31:3 ignored.
REQ-007 SHALL have port phi_locked, input, 1: phi PLL lock, asynchronous to clk.
REQ-008 SHALL have port theta_locked, input, 1: theta PLL lock, asynchronous to clk.
REQ-009 SHALL have port phi_pll_rst, output, 1: phi PLL reset, active high.
REQ-010 SHALL have port theta_pll_rst, output, 1: theta PLL reset, active high.
REQ-011 SHALL have port tdc_rst, output, 1: TDC reset, active high.
REQ-012 SHALL have port aes_rst, output, 1: AES core reset, active high.
REQ-013 SHALL have port status_word, output, 32: PIO status returned to HPS.

Function
REQ-014 SHALL pass phi_locked and theta_locked through two-flop synchronizers (phi_s, theta_s); all lock decisions use the synchronized values only.
REQ-015 SHALL detect a run start as cmd_word[0] = 1 in the current cycle with 0 registered in the previous cycle.
REQ-016 SHALL implement these states, encoded 0..7: IDLE, PHI_HOLD, PHI_WAIT, THETA_HOLD, THETA_WAIT, TDC_REL, RUN, ERROR.
REQ-017 IDLE: all four resets = 1; a run start moves to PHI_HOLD and loads the hold counter with 0.
REQ-018 PHI_HOLD: phi_pll_rst = 1 for exactly HOLD_CYCLES cycles, then moves to PHI_WAIT with phi_pll_rst = 0.
REQ-019 PHI_WAIT: phi_s = 1 moves to THETA_HOLD; theta_pll_rst, tdc_rst and aes_rst stay 1.
REQ-020 THETA_HOLD: theta_pll_rst = 1 for exactly HOLD_CYCLES cycles, then moves to THETA_WAIT with theta_pll_rst = 0.
REQ-021 THETA_WAIT: theta_s = 1 moves to TDC_REL.
REQ-022 TDC_REL: tdc_rst = 0 from this cycle onward; the block moves to RUN on the next cycle.
REQ-023 RUN: phi_pll_rst = theta_pll_rst = tdc_rst = 0; aes_rst follows registered cmd_word[1], one cycle of latency.
REQ-024 In THETA_HOLD, THETA_WAIT, TDC_REL or RUN, phi_s = 0 SHALL set lock_lost, force all resets to 1 and move to PHI_HOLD.
REQ-025 In TDC_REL or RUN, theta_s = 0 with phi_s = 1 SHALL set lock_lost, force theta_pll_rst, tdc_rst and aes_rst to 1, and move to THETA_HOLD.
REQ-026 cmd_word[0] = 0 in any non-IDLE state SHALL move to IDLE and assert all resets on the next cycle (abort).
REQ-027 Priority per cycle is: abort, then timeout, then loss of lock, then normal transition.
REQ-028 cmd_word[2] = 1 SHALL clear lock_lost and timeout_flag; a set event in the same cycle wins.
REQ-029 status_word SHALL be registered, with this layout:
- [0] phi_s;
- [1] theta_s;
- [2] state == RUN;
- [3] lock_lost;
- [4] timeout_flag;
- [7:5] = 0;
- [10:8] state code;
- [31:11] = 0.
REQ-030 The hold counter SHALL be 8 bits and the wait counter 24 bits; both clear on every state entry, and the wait counter saturates rather than wrapping.

Reset
REQ-031 While reset = 1, on the next edge:
- state = IDLE;
- phi_pll_rst = theta_pll_rst = tdc_rst = aes_rst = 1;
- status_word = 0;
- sticky flags, counters, synchronizers and the previous cmd bit cleared.
REQ-032 Reset asserted mid-sequence SHALL take effect on the next edge regardless of state.
REQ-033 A run start requires a fresh 0 to 1 edge on cmd_word[0] after reset; a level already high at reset release SHALL NOT start a run.

Configuration
REQ-034 With macro PLL_SEQ_TIMEOUT_EN defined, the timeout feature is compiled in:
- PHI_WAIT or THETA_WAIT reaching LOCK_TIMEOUT cycles moves to ERROR and sets timeout_flag;
- ERROR forces all resets to 1;
- a run start leaves ERROR to PHI_HOLD; abort leaves ERROR to IDLE.
REQ-035 Without PLL_SEQ_TIMEOUT_EN:
- the wait states wait indefinitely and ERROR is unreachable;
- status_word[4] is constant 0;
- the wait counter is not implemented.

Verification (HOLD_CYCLES=4, LOCK_TIMEOUT=100)
REQ-036 Nominal: cmd 0 then 1, phi_locked high 10 cycles later, theta_locked high 10 cycles after theta release -> phi_pll_rst high exactly 4 cycles in PHI_HOLD; then theta_pll_rst released, tdc_rst released, RUN reached, status_word = 0x604 with both locks = 0x607.
REQ-037 AES hold: in RUN, cmd = 0x3 -> aes_rst = 1 one cycle later; cmd = 0x1 -> aes_rst = 0 one cycle later.
REQ-038 Lock loss: in RUN, drop theta_locked -> after 2 sync cycles theta_pll_rst, tdc_rst and aes_rst = 1, state THETA_HOLD, status[3] = 1; cmd = 0x5 clears status[3].
REQ-039 Timeout (macro on): phi_locked held 0 -> ERROR after 100 cycles in PHI_WAIT, status[4] = 1, all resets 1; macro off: still PHI_WAIT after 1000 cycles, status[4] = 0.
REQ-040 Abort and reset: cmd = 0 during THETA_WAIT -> IDLE with all resets 1 next cycle; reset pulsed during RUN -> all outputs at reset values and status_word = 0 on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Releases the phi PLL, then the theta PLL, then the TDC and
//               AES resets in order, and supervises lock once running.
//               Define PLL_SEQ_TIMEOUT_EN to compile in the lock-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_word,
    input  logic        phi_locked,
    input  logic        theta_locked,
    output logic        phi_pll_rst,
    output logic        theta_pll_rst,
    output logic        tdc_rst,
    output logic        aes_rst,
    output logic [31:0] status_word
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PHI_HOLD   = 3'd1,
        S_PHI_WAIT   = 3'd2,
        S_THETA_HOLD = 3'd3,
        S_THETA_WAIT = 3'd4,
        S_TDC_REL    = 3'd5,
        S_RUN        = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

    localparam logic [7:0] c_hold_last = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_phi_meta, r_phi_s;
    logic        r_theta_meta, r_theta_s;
    logic        r_run_prev, r_run_armed;
    logic [7:0]  r_hold_cnt;
    logic        r_lock_lost;
    logic        r_phi_rst, r_theta_rst, r_tdc_rst, r_aes_rst;
    logic [31:0] r_status_word;

    logic        w_run_start, w_abort, w_phi_loss, w_theta_loss;
    logic        w_timeout_evt, w_timeout_take, w_lock_take;
    logic        w_lock_lost_next, w_timeout_next, w_state_change;
    logic        w_phi_rst_nxt, w_theta_rst_nxt, w_tdc_rst_nxt, w_aes_rst_nxt;
    logic [31:0] w_status_next;
    logic        w_cmd_unused;

    assign w_cmd_unused = ^cmd_word[31:3];

    // Lock inputs are asynchronous; only the second flop feeds decisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phi_meta   <= 1'b0;
            r_phi_s      <= 1'b0;
            r_theta_meta <= 1'b0;
            r_theta_s    <= 1'b0;
            r_run_prev   <= 1'b0;
            r_run_armed  <= 1'b0;
        end else begin
            r_phi_meta   <= phi_locked;
            r_phi_s      <= r_phi_meta;
            r_theta_meta <= theta_locked;
            r_theta_s    <= r_theta_meta;
            r_run_prev   <= cmd_word[0];
            if (!cmd_word[0]) begin
                r_run_armed <= 1'b1;
            end
        end
    end

    // Armed only after a low sample, so a level held through reset never starts.
    assign w_run_start    = cmd_word[0] & ~r_run_prev & r_run_armed;
    assign w_abort        = (r_state != S_IDLE) && !cmd_word[0];
    assign w_phi_loss     = !r_phi_s && ((r_state == S_THETA_HOLD) || (r_state == S_THETA_WAIT) ||
                                         (r_state == S_TDC_REL)    || (r_state == S_RUN));
    assign w_theta_loss   = !r_theta_s && ((r_state == S_TDC_REL) || (r_state == S_RUN));
    assign w_state_change = (w_next_state != r_state);

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [23:0] c_wait_last = 24'(LOCK_TIMEOUT - 1);

    logic [23:0] r_wait_cnt;
    logic        r_timeout_flag;

    assign w_timeout_evt  = ((r_state == S_PHI_WAIT) || (r_state == S_THETA_WAIT)) &&
                            (r_wait_cnt >= c_wait_last);
    assign w_timeout_next = w_timeout_take ? 1'b1 : (cmd_word[2] ? 1'b0 : r_timeout_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt     <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_timeout_flag <= w_timeout_next;
            if (w_state_change) begin
                r_wait_cnt <= '0;
            end else if (((r_state == S_PHI_WAIT) || (r_state == S_THETA_WAIT)) &&
                         (r_wait_cnt != 24'hFF_FFFF)) begin
                r_wait_cnt <= r_wait_cnt + 24'd1;
            end
        end
    end
`else
    localparam int c_unused_timeout = LOCK_TIMEOUT;

    assign w_timeout_evt  = 1'b0;
    assign w_timeout_next = 1'b0;
`endif

    // Priority: abort, timeout, phi loss, theta loss, normal progression.
    always_comb begin
        w_next_state   = r_state;
        w_timeout_take = 1'b0;
        w_lock_take    = 1'b0;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else if (w_timeout_evt) begin
            w_next_state   = S_ERROR;
            w_timeout_take = 1'b1;
        end else if (w_phi_loss) begin
            w_next_state = S_PHI_HOLD;
            w_lock_take  = 1'b1;
        end else if (w_theta_loss) begin
            w_next_state = S_THETA_HOLD;
            w_lock_take  = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE, S_ERROR: if (w_run_start)               w_next_state = S_PHI_HOLD;
                S_PHI_HOLD:      if (r_hold_cnt == c_hold_last) w_next_state = S_PHI_WAIT;
                S_PHI_WAIT:      if (r_phi_s)                   w_next_state = S_THETA_HOLD;
                S_THETA_HOLD:    if (r_hold_cnt == c_hold_last) w_next_state = S_THETA_WAIT;
                S_THETA_WAIT:    if (r_theta_s)                 w_next_state = S_TDC_REL;
                S_TDC_REL:       w_next_state = S_RUN;
                S_RUN:           w_next_state = S_RUN;
                default:         w_next_state = S_IDLE;
            endcase
        end
    end

    assign w_lock_lost_next = w_lock_take ? 1'b1 : (cmd_word[2] ? 1'b0 : r_lock_lost);

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_phi_rst_nxt   = 1'b1;
        w_theta_rst_nxt = 1'b1;
        w_tdc_rst_nxt   = 1'b1;
        w_aes_rst_nxt   = 1'b1;
        unique case (w_next_state)
            S_PHI_WAIT, S_THETA_HOLD: begin
                w_phi_rst_nxt = 1'b0;
            end
            S_THETA_WAIT: begin
                w_phi_rst_nxt   = 1'b0;
                w_theta_rst_nxt = 1'b0;
            end
            S_TDC_REL: begin
                w_phi_rst_nxt   = 1'b0;
                w_theta_rst_nxt = 1'b0;
                w_tdc_rst_nxt   = 1'b0;
            end
            S_RUN: begin
                w_phi_rst_nxt   = 1'b0;
                w_theta_rst_nxt = 1'b0;
                w_tdc_rst_nxt   = 1'b0;
                w_aes_rst_nxt   = cmd_word[1];
            end
            default: begin
                w_phi_rst_nxt = 1'b1;
            end
        endcase
    end

    assign w_status_next = {21'd0, w_next_state, 3'd0, w_timeout_next, w_lock_lost_next,
                            (w_next_state == S_RUN), r_theta_meta, r_phi_meta};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_lock_lost   <= 1'b0;
            r_phi_rst     <= 1'b1;
            r_theta_rst   <= 1'b1;
            r_tdc_rst     <= 1'b1;
            r_aes_rst     <= 1'b1;
            r_status_word <= '0;
        end else begin
            r_state       <= w_next_state;
            r_lock_lost   <= w_lock_lost_next;
            r_phi_rst     <= w_phi_rst_nxt;
            r_theta_rst   <= w_theta_rst_nxt;
            r_tdc_rst     <= w_tdc_rst_nxt;
            r_aes_rst     <= w_aes_rst_nxt;
            r_status_word <= w_status_next;
            if (w_state_change) begin
                r_hold_cnt <= '0;
            end else if ((r_state == S_PHI_HOLD) || (r_state == S_THETA_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign phi_pll_rst   = r_phi_rst;
    assign theta_pll_rst = r_theta_rst;
    assign tdc_rst       = r_tdc_rst;
    assign aes_rst       = r_aes_rst;
    assign status_word   = r_status_word;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer (HOLD=4,
//               TIMEOUT=100) against a behavioural bring-up model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int HOLD    = 4;
    localparam int TIMEOUT = 100;
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_PHI_HOLD = 1, S_PHI_WAIT = 2, S_THETA_HOLD = 3;
    localparam int S_THETA_WAIT = 4, S_TDC_REL = 5, S_RUN = 6, S_ERROR = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_word;
    logic        phi_locked, theta_locked;
    logic        phi_pll_rst, theta_pll_rst, tdc_rst, aes_rst;
    logic [31:0] status_word;
    logic [35:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(.HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_word     (cmd_word),
        .phi_locked   (phi_locked),
        .theta_locked (theta_locked),
        .phi_pll_rst  (phi_pll_rst),
        .theta_pll_rst(theta_pll_rst),
        .tdc_rst      (tdc_rst),
        .aes_rst      (aes_rst),
        .status_word  (status_word)
    );

    always #5 clk = ~clk;

    assign dut_vec = {phi_pll_rst, theta_pll_rst, tdc_rst, aes_rst, status_word};

    // Behavioural model: state, cycles spent in it, and a two-deep lock pipeline.
    int          m_state = S_IDLE;
    int          m_age   = 0;
    bit          m_phi_m, m_phi_s, m_th_m, m_th_s;
    bit          m_prev, m_seen_low, m_lost, m_tmo, m_aes = 1'b1;
    logic [31:0] m_status = '0;

    task automatic model_step();
        int nxt;
        bit start, lost_ev, tmo_ev, released;
        if (reset) begin
            m_state = S_IDLE; m_age = 0; m_phi_m = 0; m_phi_s = 0; m_th_m = 0; m_th_s = 0;
            m_prev = 0; m_seen_low = 0; m_lost = 0; m_tmo = 0; m_aes = 1; m_status = '0;
            return;
        end
        start   = cmd_word[0] && !m_prev && m_seen_low;
        nxt     = m_state;
        lost_ev = 0;
        tmo_ev  = 0;
        released = (m_state >= S_THETA_HOLD) && (m_state <= S_RUN);
        if (m_state != S_IDLE && !cmd_word[0]) nxt = S_IDLE;
        else if (TMO_EN && (m_state == S_PHI_WAIT || m_state == S_THETA_WAIT) && m_age + 1 >= TIMEOUT) begin
            nxt = S_ERROR; tmo_ev = 1;
        end else if (released && !m_phi_s) begin
            nxt = S_PHI_HOLD; lost_ev = 1;
        end else if ((m_state == S_TDC_REL || m_state == S_RUN) && !m_th_s) begin
            nxt = S_THETA_HOLD; lost_ev = 1;
        end else begin
            case (m_state)
                S_IDLE, S_ERROR: if (start)             nxt = S_PHI_HOLD;
                S_PHI_HOLD:      if (m_age + 1 == HOLD) nxt = S_PHI_WAIT;
                S_PHI_WAIT:      if (m_phi_s)           nxt = S_THETA_HOLD;
                S_THETA_HOLD:    if (m_age + 1 == HOLD) nxt = S_THETA_WAIT;
                S_THETA_WAIT:    if (m_th_s)            nxt = S_TDC_REL;
                S_TDC_REL:       nxt = S_RUN;
                default:         nxt = m_state;
            endcase
        end
        if (lost_ev) m_lost = 1; else if (cmd_word[2]) m_lost = 0;
        if (tmo_ev)  m_tmo  = 1; else if (cmd_word[2]) m_tmo  = 0;
        m_age   = (nxt != m_state) ? 0 : m_age + 1;
        m_state = nxt;
        m_aes   = (nxt == S_RUN) ? cmd_word[1] : 1'b1;
        m_phi_s = m_phi_m; m_phi_m = phi_locked;
        m_th_s  = m_th_m;  m_th_m  = theta_locked;
        m_prev  = cmd_word[0];
        if (!cmd_word[0]) m_seen_low = 1;
        m_status = {21'd0, 3'(m_state), 3'd0, m_tmo, m_lost, (m_state == S_RUN), m_th_s, m_phi_s};
    endtask

    // Each PLL/TDC reset is released once the sequence has passed its stage.
    function automatic logic [35:0] exp_vec();
        bit phi_r, th_r, tdc_r;
        phi_r = !(m_state >= S_PHI_WAIT && m_state <= S_RUN);
        th_r  = !(m_state >= S_THETA_WAIT && m_state <= S_RUN);
        tdc_r = !(m_state >= S_TDC_REL && m_state <= S_RUN);
        return {phi_r, th_r, tdc_r, m_aes, m_status};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_word = '0; phi_locked = 0; theta_locked = 0;
        repeat (3) tick();
        n_checks++;
        if (dut_vec !== {4'hF, 32'h0}) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", dut_vec, {4'hF, 32'h0});
        end
        cmd_word = 32'h1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_release cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (status_word[10:8] !== 3'd0 || phi_pll_rst !== 1'b1) begin
            n_fail++; $display("FAIL no_start_on_level: state %0d phi_rst %b want 0 1", status_word[10:8], phi_pll_rst);
        end
    endtask

    task automatic test_nominal();
        int hold_hi = 0;
        cmd_word = 32'h0;
        tick(); tick();
        cmd_word = 32'h1;
        for (int c = 0; c < 60; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL nominal cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (status_word[10:8] == 3'd1 && phi_pll_rst) hold_hi++;
            if (m_state == S_PHI_WAIT && m_age == 9)   phi_locked   = 1'b1;
            if (m_state == S_THETA_WAIT && m_age == 9) theta_locked = 1'b1;
        end
        n_checks++;
        if (hold_hi != HOLD) begin
            n_fail++; $display("FAIL phi_hold_len: got %0d want %0d", hold_hi, HOLD);
        end
        n_checks++;
        if (status_word !== 32'h607) begin
            n_fail++; $display("FAIL run_status: got %h want 00000607", status_word);
        end
    endtask

    task automatic test_aes_hold();
        cmd_word = 32'h3;
        #1;
        n_checks++;
        if (aes_rst !== 1'b0) begin
            n_fail++; $display("FAIL aes_latency: got %b want 0 before edge", aes_rst);
        end
        tick();
        n_checks++;
        if (aes_rst !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL aes_hold_on: got %h want %h", dut_vec, exp_vec());
        end
        cmd_word = 32'h1;
        tick();
        n_checks++;
        if (aes_rst !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL aes_hold_off: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lock_loss();
        theta_locked = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL theta_loss cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if ({theta_pll_rst, tdc_rst, aes_rst} !== 3'b111 || status_word[10:8] !== 3'd3 || status_word[3] !== 1'b1) begin
            n_fail++; $display("FAIL theta_loss_state: got rst %b%b%b status %h want 111 state 3 lost 1",
                               theta_pll_rst, tdc_rst, aes_rst, status_word);
        end
        cmd_word = 32'h5;
        tick();
        n_checks++;
        if (status_word[3] !== 1'b0) begin
            n_fail++; $display("FAIL lost_clear: got %b want 0", status_word[3]);
        end
        cmd_word = 32'h1; theta_locked = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL relock cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        int n_cyc;
        cmd_word = 32'h0; phi_locked = 0; theta_locked = 0;
        tick(); tick(); tick();
        cmd_word = 32'h1;
        n_cyc = TMO_EN ? (HOLD + TIMEOUT + 6) : 1004;
        for (int c = 0; c < n_cyc; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL timeout_seq cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (TMO_EN) begin
            if (status_word[10:8] !== 3'd7 || status_word[4] !== 1'b1 || dut_vec[35:32] !== 4'hF) begin
                n_fail++; $display("FAIL timeout_error: got %h want state 7 tmo 1 resets F", dut_vec);
            end
        end else begin
            if (status_word[10:8] !== 3'd2 || status_word[4] !== 1'b0) begin
                n_fail++; $display("FAIL wait_forever: got %h want state 2 tmo 0", status_word);
            end
        end
        cmd_word = 32'h4;
        tick();
        n_checks++;
        if (dut_vec !== exp_vec() || status_word[4] !== 1'b0) begin
            n_fail++; $display("FAIL timeout_abort: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_abort();
        cmd_word = 32'h1; phi_locked = 1'b1; theta_locked = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL abort_seq cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (status_word[10:8] !== 3'd4) begin
            n_fail++; $display("FAIL reach_theta_wait: got %0d want 4", status_word[10:8]);
        end
        cmd_word = 32'h0;
        tick();
        n_checks++;
        if (dut_vec[35:32] !== 4'hF || status_word[10:8] !== 3'd0) begin
            n_fail++; $display("FAIL abort_idle: got %h want resets F state 0", dut_vec);
        end
    endtask

    task automatic test_reset_mid();
        cmd_word = 32'h1; theta_locked = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid_seq cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (status_word !== 32'h607) begin
            n_fail++; $display("FAIL reset_mid_run: got %h want 00000607", status_word);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (dut_vec !== {4'hF, 32'h0}) begin
            n_fail++; $display("FAIL reset_mid: got %h want %h", dut_vec, {4'hF, 32'h0});
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) cmd_word[0] = ~cmd_word[0];
            cmd_word[1]    = ($urandom_range(0, 7) == 0) ? ~cmd_word[1] : cmd_word[1];
            cmd_word[2]    = ($urandom_range(0, 19) == 0);
            cmd_word[31:3] = 29'($urandom);
            if ($urandom_range(0, 59) == 0) phi_locked   = ~phi_locked;
            if ($urandom_range(0, 39) == 0) theta_locked = ~theta_locked;
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_word = '0; phi_locked = 1'b0; theta_locked = 1'b0;
        test_reset();
        test_nominal();
        test_aes_hold();
        test_lock_loss();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
